// File: rtl/mpu_fault_unit.sv
// Fault capture stage behind the MPU: kills faulting accesses, latches the syndrome,
// raises a level IRQ toward the n-CLIC and exposes FAULTADDR/FAULTINFO/FAULTCLR CSRs.
module mpu_fault_unit #(
    parameter logic [11:0] Base       = 12'h420,
    parameter int          CountWidth = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_fault_i,
    input  logic        mem_valid_i,
    input  logic [15:0] mem_addr_i,
    input  logic [6:0]  mem_op_i,
    input  logic [2:0]  task_id_i,
    output logic        mem_kill_o,
    output logic        irq_req_o,
    input  logic        irq_ack_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_hit_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACTIVE  = 2'd2
    } state_e;

    localparam logic [11:0]           AddrFaultAddr = Base;
    localparam logic [11:0]           AddrFaultInfo = Base + 12'd1;
    localparam logic [11:0]           AddrFaultClr  = Base + 12'd2;
    localparam logic [CountWidth-1:0] CountMax      = '1;

    state_e                state_q, state_d;
    logic                  irq_q, irq_d;
    logic [15:0]           addr_q, addr_d;
    logic [6:0]            op_q, op_d;
    logic [2:0]            id_q, id_d;
    logic                  overflow_q, overflow_d;
    logic [CountWidth-1:0] count_q, count_d;

    logic                  faultEvent;
    logic                  clrState;
    logic                  clrCount;
    state_e                baseState;
    logic [7:0]            countExt;
    logic                  unusedWdata;

    assign faultEvent  = mem_fault_i & mem_valid_i;
    assign mem_kill_o  = faultEvent;
    assign clrState    = csr_we_i && (csr_addr_i == AddrFaultClr) && csr_wdata_i[0];
    assign clrCount    = csr_we_i && (csr_addr_i == AddrFaultClr) && csr_wdata_i[1];
    assign unusedWdata = ^csr_wdata_i[31:2];
    assign irq_req_o   = irq_q;

    // A clear is applied before the fault, so a concurrent fault is captured as if from IDLE.
    always_comb begin
        baseState  = clrState ? IDLE : state_q;
        state_d    = baseState;
        addr_d     = addr_q;
        op_d       = op_q;
        id_d       = id_q;
        overflow_d = clrState ? 1'b0 : overflow_q;
        count_d    = clrCount ? '0 : count_q;

        if (faultEvent && (count_d != CountMax)) begin
            count_d = count_d + 1'b1;
        end

        if (faultEvent && (baseState == IDLE)) begin
            state_d = PENDING;
            addr_d  = mem_addr_i;
            op_d    = mem_op_i;
            id_d    = task_id_i;
        end else begin
            if (faultEvent) begin
                overflow_d = 1'b1;
            end
            if ((baseState == PENDING) && irq_ack_i) begin
                state_d = ACTIVE;
            end
        end

        irq_d = (state_d == PENDING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            irq_q      <= 1'b0;
            addr_q     <= '0;
            op_q       <= '0;
            id_q       <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            id_q       <= id_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        countExt                 = '0;
        countExt[CountWidth-1:0] = count_q;
    end

    always_comb begin
        csr_rdata_o = '0;
        csr_hit_o   = 1'b0;
        case (csr_addr_i)
            AddrFaultAddr: begin
                csr_hit_o   = 1'b1;
                csr_rdata_o = {16'b0, addr_q};
            end
            AddrFaultInfo: begin
                csr_hit_o   = 1'b1;
                csr_rdata_o = {8'b0, countExt, 2'b0, overflow_q, state_q, id_q, 1'b0, op_q};
            end
            AddrFaultClr: begin
                csr_hit_o = 1'b1;
            end
            default: begin
                csr_hit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mpu_fault_unit.sv
// Directed bench for mpu_fault_unit: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_mpu_fault_unit;

    localparam logic [11:0] FaultAddr = 12'h420;
    localparam logic [11:0] FaultInfo = 12'h421;
    localparam logic [11:0] FaultClr  = 12'h422;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_fault_i, mem_valid_i;
    logic [15:0] mem_addr_i;
    logic [6:0]  mem_op_i;
    logic [2:0]  task_id_i;
    logic        mem_kill_o, irq_req_o, irq_ack_i;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];
    logic [31:0] rd;

    mpu_fault_unit #(.Base(12'h420), .CountWidth(8)) dut (
        .clk(clk), .reset(reset),
        .mem_fault_i(mem_fault_i), .mem_valid_i(mem_valid_i),
        .mem_addr_i(mem_addr_i), .mem_op_i(mem_op_i), .task_id_i(task_id_i),
        .mem_kill_o(mem_kill_o), .irq_req_o(irq_req_o), .irq_ack_i(irq_ack_i),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, well away from the sampling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(input string tag, input logic [31:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        logic [31:0] expected;
        string       tag;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
        end else begin
            expected = expQ.pop_front();
            tag      = tagQ.pop_front();
            assert (observed === expected) else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    task automatic readCsr(input logic [11:0] addr, output logic [31:0] data);
        csr_addr_i = addr;
        #1;
        data = csr_rdata_o;
    endtask

    task automatic checkCsr(input string tag, input logic [11:0] addr, input logic [31:0] value);
        expectVal(tag, value);
        readCsr(addr, rd);
        checkOutput(rd);
    endtask

    task automatic checkIrq(input string tag, input logic value);
        expectVal(tag, {31'b0, value});
        checkOutput({31'b0, irq_req_o});
    endtask

    task automatic applyStimulus(input logic fault, input logic valid, input logic [15:0] addr,
                                 input logic [6:0] op, input logic [2:0] id);
        mem_fault_i = fault;
        mem_valid_i = valid;
        mem_addr_i  = addr;
        mem_op_i    = op;
        task_id_i   = id;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 16'h0, 7'h0, 3'h0);
        irq_ack_i   = 1'b0;
        csr_we_i    = 1'b0;
        csr_wdata_i = '0;
    endtask

    task automatic writeCsr(input logic [11:0] addr, input logic [31:0] data);
        csr_we_i    = 1'b1;
        csr_addr_i  = addr;
        csr_wdata_i = data;
    endtask

    initial begin
        reset      = 1'b1;
        csr_addr_i = '0;
        idleInputs();
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state and address decode
        checkIrq("reset_irq", 1'b0);
        checkCsr("reset_addr", FaultAddr, 32'h0);
        checkCsr("reset_info", FaultInfo, 32'h0);
        checkCsr("reset_clr", FaultClr, 32'h0);
        expectVal("hit_base", 32'h1);
        readCsr(FaultAddr, rd);
        checkOutput({31'b0, csr_hit_o});
        expectVal("hit_below", 32'h0);
        readCsr(12'h41F, rd);
        checkOutput({31'b0, csr_hit_o});
        expectVal("hit_above", 32'h0);
        readCsr(12'h423, rd);
        checkOutput({31'b0, csr_hit_o});

        // Writes to the read-only syndrome CSRs are ignored
        writeCsr(FaultAddr, 32'hFFFF_FFFF);
        cycle();
        writeCsr(FaultInfo, 32'hFFFF_FFFF);
        cycle();
        idleInputs();
        checkCsr("ro_addr", FaultAddr, 32'h0);
        checkCsr("ro_info", FaultInfo, 32'h0);

        // Store fault at 0x1234 by task 5
        applyStimulus(1'b1, 1'b1, 16'h1234, 7'h23, 3'd5);
        #1;
        expectVal("kill_store", 32'h1);
        checkOutput({31'b0, mem_kill_o});
        cycle();
        idleInputs();
        checkIrq("irq_pending", 1'b1);
        checkCsr("addr_store", FaultAddr, 32'h0000_1234);
        checkCsr("info_store", FaultInfo, 32'h0001_0D23);

        // Ack moves to ACTIVE and drops the request
        irq_ack_i = 1'b1;
        cycle();
        idleInputs();
        checkIrq("irq_acked", 1'b0);
        checkCsr("info_active", FaultInfo, 32'h0001_1523);

        // Load fault while ACTIVE: syndrome held, overflow and count rise
        applyStimulus(1'b1, 1'b1, 16'h2000, 7'h03, 3'd2);
        cycle();
        idleInputs();
        checkCsr("addr_held", FaultAddr, 32'h0000_1234);
        checkCsr("info_ovf", FaultInfo, 32'h0002_3523);

        writeCsr(FaultClr, 32'h1);
        cycle();
        idleInputs();
        checkCsr("info_clr1", FaultInfo, 32'h0002_0523);
        writeCsr(FaultClr, 32'h2);
        cycle();
        idleInputs();
        checkCsr("info_clr2", FaultInfo, 32'h0000_0523);

        // Fault flag without a valid access is ignored
        applyStimulus(1'b1, 1'b0, 16'hBEEF, 7'h23, 3'd4);
        #1;
        expectVal("kill_novalid", 32'h0);
        checkOutput({31'b0, mem_kill_o});
        for (int i = 0; i < 10; i++) cycle();
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 7'h23, 3'd4);
        #1;
        expectVal("kill_nofault", 32'h0);
        checkOutput({31'b0, mem_kill_o});
        cycle();
        idleInputs();
        checkIrq("irq_novalid", 1'b0);
        checkCsr("info_novalid", FaultInfo, 32'h0000_0523);

        // Ack in IDLE is ignored
        irq_ack_i = 1'b1;
        cycle();
        idleInputs();
        checkCsr("info_ack_idle", FaultInfo, 32'h0000_0523);

        // Fault + ack in IDLE captures and goes PENDING
        applyStimulus(1'b1, 1'b1, 16'h2000, 7'h03, 3'd2);
        irq_ack_i = 1'b1;
        cycle();
        idleInputs();
        checkIrq("irq_fault_ack_idle", 1'b1);
        checkCsr("addr_fault_ack_idle", FaultAddr, 32'h0000_2000);
        checkCsr("info_fault_ack_idle", FaultInfo, 32'h0001_0A03);

        // Fault + ack in PENDING: ACTIVE, overflow, old syndrome kept
        applyStimulus(1'b1, 1'b1, 16'h3333, 7'h23, 3'd7);
        irq_ack_i = 1'b1;
        cycle();
        idleInputs();
        checkIrq("irq_fault_ack_pend", 1'b0);
        checkCsr("addr_fault_ack_pend", FaultAddr, 32'h0000_2000);
        checkCsr("info_fault_ack_pend", FaultInfo, 32'h0002_3203);

        // Fault + clear while ACTIVE: new capture, overflow cleared
        applyStimulus(1'b1, 1'b1, 16'h4444, 7'h23, 3'd1);
        writeCsr(FaultClr, 32'h1);
        cycle();
        idleInputs();
        checkIrq("irq_fault_clr", 1'b1);
        checkCsr("addr_fault_clr", FaultAddr, 32'h0000_4444);
        checkCsr("info_fault_clr", FaultInfo, 32'h0003_0923);

        // Software abort from PENDING, also clearing count
        writeCsr(FaultClr, 32'h3);
        cycle();
        idleInputs();
        checkIrq("irq_abort", 1'b0);
        checkCsr("info_abort", FaultInfo, 32'h0000_0123);

        // Fault + clear(0x3): count restarts at 1
        applyStimulus(1'b1, 1'b1, 16'h5555, 7'h03, 3'd6);
        writeCsr(FaultClr, 32'h3);
        cycle();
        idleInputs();
        checkCsr("info_fault_clr3", FaultInfo, 32'h0001_0E03);

        // Read during the update cycle returns the pre-edge value
        irq_ack_i = 1'b1;
        checkCsr("info_pre_edge", FaultInfo, 32'h0001_0E03);
        cycle();
        idleInputs();
        checkCsr("info_post_edge", FaultInfo, 32'h0001_1603);

        // 300 fault events saturate the counter at 255
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0F0F, 7'h23, 3'd0);
            cycle();
        end
        idleInputs();
        checkCsr("addr_sat", FaultAddr, 32'h0000_5555);
        checkCsr("info_sat", FaultInfo, 32'h00FF_3603);

        writeCsr(FaultClr, 32'h1);
        cycle();
        applyStimulus(1'b1, 1'b1, 16'h0ABC, 7'h23, 3'd3);
        csr_we_i = 1'b0;
        cycle();
        idleInputs();
        checkIrq("irq_sat_capture", 1'b1);
        checkCsr("info_sat_capture", FaultInfo, 32'h00FF_0B23);

        // Reset mid-PENDING overrides a concurrent fault, ack and CSR write
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h7777, 7'h03, 3'd7);
        irq_ack_i = 1'b1;
        writeCsr(FaultClr, 32'h0);
        cycle();
        reset = 1'b0;
        idleInputs();
        checkIrq("irq_after_reset", 1'b0);
        checkCsr("addr_after_reset", FaultAddr, 32'h0);
        checkCsr("info_after_reset", FaultInfo, 32'h0);
        checkCsr("clr_after_reset", FaultClr, 32'h0);

        if (expQ.size() != 0) begin
            total++;
            bad++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
